// File: rtl/fir_pkg.sv
// Shared types and sizing for the FIR accelerator front-end sequencer.
package fir_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int NUM_REGS   = 8;
    localparam int ADDR_WIDTH = $clog2(NUM_REGS);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, RUN} fir_seq_state_t;

    typedef logic signed [DATA_WIDTH-1:0] fir_word_t;

endpackage

// File: rtl/fir_sequencer.sv
// Sequences coefficient reloads, gates samples into the MAC datapath and
// suppresses warm-up results until the delay line has filled.
module fir_sequencer #(
    parameter int DATA_WIDTH = fir_pkg::DATA_WIDTH,
    parameter int NUM_REGS   = fir_pkg::NUM_REGS,
    parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  cfgStart,
    input  logic                  cfgValid,
    input  logic [DATA_WIDTH-1:0] cfgData,
    output logic                  cfgReady,
    input  logic                  sampleValid,
    input  logic [DATA_WIDTH-1:0] sampleData,
    output logic                  sampleReady,
    output logic                  coeffWriteEn,
    output logic [ADDR_WIDTH-1:0] coeffAddress,
    output logic [DATA_WIDTH-1:0] coeffsIn,
    output logic                  clrC,
    output logic                  accelerateEn,
    output logic [DATA_WIDTH-1:0] rawSensorVal,
    input  logic [DATA_WIDTH-1:0] macResult,
    input  logic                  resultIsValid,
    output logic                  outValid,
    output logic [DATA_WIDTH-1:0] outData,
    output logic                  busy,
    output logic                  loadDone
);
    import fir_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(NUM_REGS - 1);

    fir_seq_state_t        state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] warm_q, warm_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] cin_q, cin_d;
    logic                  clr_q, clr_d;
    logic                  acc_q, acc_d;
    logic [DATA_WIDTH-1:0] raw_q, raw_d;
    logic                  ov_q, ov_d;
    logic [DATA_WIDTH-1:0] od_q, od_d;
    logic                  done_q, done_d;
    logic                  sample_accept_s;

    assign cfgReady        = (state_q == LOAD);
    assign sampleReady     = (state_q == RUN) && !cfgStart;
    assign busy            = (state_q != RUN);
    assign sample_accept_s = sampleValid && sampleReady;

    // Next-state and next-output computation for the whole sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        warm_d  = warm_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        cin_d   = cin_q;
        clr_d   = 1'b0;
        acc_d   = 1'b0;
        raw_d   = raw_q;
        ov_d    = 1'b0;
        od_d    = od_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfgStart) begin
                    state_d = LOAD;
                    cnt_d   = ADDR_ZERO;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (cfgValid) begin
                    we_d   = 1'b1;
                    addr_d = cnt_q;
                    cin_d  = cfgData;
                    if (cnt_q == ADDR_LAST) begin
                        state_d = FLUSH;
                    end else begin
                        cnt_d = cnt_q + ADDR_ONE;
                    end
                end else begin
                    we_d = 1'b0;
                end
            end
            FLUSH: begin
                clr_d   = 1'b1;
                warm_d  = ADDR_ZERO;
                done_d  = 1'b1;
                state_d = RUN;
            end
            RUN: begin
                if (sample_accept_s) begin
                    acc_d = 1'b1;
                    raw_d = sampleData;
                end else begin
                    acc_d = 1'b0;
                end
                // Results only pass once NUM_REGS-1 earlier results have primed the delay line.
                if (resultIsValid) begin
                    if (warm_q == ADDR_LAST) begin
                        ov_d = 1'b1;
                        od_d = macResult;
                    end else begin
                        warm_d = warm_q + ADDR_ONE;
                    end
                end else begin
                    ov_d = 1'b0;
                end
                if (cfgStart) begin
                    state_d = LOAD;
                    cnt_d   = ADDR_ZERO;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            cnt_q   <= ADDR_ZERO;
            warm_q  <= ADDR_ZERO;
            we_q    <= 1'b0;
            addr_q  <= ADDR_ZERO;
            cin_q   <= {DATA_WIDTH{1'b0}};
            clr_q   <= 1'b0;
            acc_q   <= 1'b0;
            raw_q   <= {DATA_WIDTH{1'b0}};
            ov_q    <= 1'b0;
            od_q    <= {DATA_WIDTH{1'b0}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            warm_q  <= warm_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            cin_q   <= cin_d;
            clr_q   <= clr_d;
            acc_q   <= acc_d;
            raw_q   <= raw_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            done_q  <= done_d;
        end
    end

    assign coeffWriteEn = we_q;
    assign coeffAddress = addr_q;
    assign coeffsIn     = cin_q;
    assign clrC         = clr_q;
    assign accelerateEn = acc_q;
    assign rawSensorVal = raw_q;
    assign outValid     = ov_q;
    assign outData      = od_q;
    assign loadDone     = done_q;

endmodule
